butterfly_stage: RTL and testbench
==================================

// Module: butterfly_stage
// PURPOSE
//  Radix-2 DIT butterfly engine between two FFT stage RAMs: reads pairs from upstream stage RAM,
//  multiplies the second by a twiddle, writes sum/difference pairs to the downstream stage RAM.
//  One instance per FFT stage; STAGE selects stride. Started by a pulse; signals done when complete.
// PARAMETERS
//  N      8   FFT length (power of 2, >=4)
//  LOG_N  3   log2(N)
//  WIDTH  32  complex sample: [WIDTH-1:WIDTH/2] real, [WIDTH/2-1:0] imag, signed Q1.(WIDTH/2-1)
//  STAGE  0   stage index 0..LOG_N-1; stride = 2^STAGE
// PORTS
//  clk       in   1        clock
//  rst_n     in   1        reset, asynchronous, active-low
//  start     in   1        one-cycle pulse: begin processing one frame
//  active    out  1        high from cycle after accepted start until done cycle (exclusive)
//  done      out  1        one-cycle pulse: all N/2 butterflies written
//  error     out  1        sticky: start seen while active
//  rd_addr0  out  LOG_N    upstream RAM read address, element A (combinational-read RAM)
//  rd_addr1  out  LOG_N    upstream RAM read address, element B
//  rd_data0  in   WIDTH    A, valid same cycle as rd_addr0
//  rd_data1  in   WIDTH    B, valid same cycle as rd_addr1
//  tf_addr   out  LOG_N-1  twiddle ROM index t, W = exp(-2*pi*i*t/N)
//  tf_data   in   WIDTH    twiddle, valid cycle after tf_addr (registered ROM)
//  wr_addr0  out  LOG_N    downstream write address X0
//  wr_addr1  out  LOG_N    downstream write address X1
//  wr_data0  out  WIDTH    X0
//  wr_data1  out  WIDTH    X1
//  wr_nd     out  1        write strobe; downstream writes both words at clk edge ending this cycle
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pipeline valids cleared. Reset mid-frame aborts: no further wr_nd.
//  States: IDLE -(start)-> RUN -(k==N/2-1 issued)-> DRAIN -(pipeline empty)-> DONE -> IDLE.
//  Start cycle = cycle 0. RUN issues butterfly k=0..N/2-1 in cycles 1..N/2, one per cycle, no stalls.
//  Addressing for k: s=2^STAGE, j=k mod s, g=k/s; rd_addr0=2*s*g+j, rd_addr1=rd_addr0+s;
//   tf_addr = j*(N/(2*s)). wr_addr0/1 equal rd_addr0/1 of same k, delayed with the data.
//  Pipeline (issue cycle c): end c capture A,B,addrs; c+1 complex mult P=W*B registered;
//   c+2 add/sub registered; c+3 wr_* valid, wr_nd=1. Latency exactly 3 cycles.
//  Mult: each real product HxH -> 2H bits (H=WIDTH/2); Pr=Wr*Br-Wi*Bi, Pi=Wr*Bi+Wi*Br in 2H+1 bits;
//   keep bits [2H-2:H-1] (truncate, Q1.(H-1)).
//  Add: X0=(A+P)>>>1, X1=(A-P)>>>1 per component, H+1-bit sum, arithmetic shift (floor). Never wraps.
//  wr_nd high cycles 4..N/2+3; done pulse cycle N/2+4; active high cycles 1..N/2+3.
//  wr_data/wr_addr hold last value when wr_nd=0.
//  start while active (RUN/DRAIN/DONE): ignored, error<=1 until reset. start in IDLE: accepted.
//  start coincident with done cycle: error, ignored; next start in IDLE accepted normally.
//  Upstream RAM must be stable from cycle 1 to N/2; module does not check this.
// TESTING
//  N=8,STAGE=1: start -> rd_addr pairs (0,2),(1,3),(4,6),(5,7) cycles 1-4; tf_addr 0,2,0,2.
//  A=0x40000000, B=0x20000000, W=0x7FFF0000 -> X0=0x2FFF0000, X1=0x10000000, wr_nd cycle 4.
//  A=0, B=0x00004000 (i/2), W=0x00008000 (-i) -> P real=0x4000; X0=0x20000000, X1=0xE0000000.
//  N=8,STAGE=2: pairs (0,4),(1,5),(2,6),(3,7), tf_addr 0,1,2,3; done exactly cycle 8, one cycle wide.
//  start pulsed in cycle 3 -> error=1 sticky, sequence/done timing unchanged; rst_n low -> error=0.
//  rst_n asserted cycle 5 -> all outputs 0 immediately, no wr_nd after; new start runs clean frame.

Source files
------------

// File: rtl/butterfly_stage.sv
// Radix-2 DIT butterfly engine for one FFT stage.
// Reads A/B pairs from the upstream stage RAM, forms P = W*B and writes
// X0 = (A+P)/2, X1 = (A-P)/2 to the downstream stage RAM. The pipeline is
// three cycles deep and issues one butterfly per cycle with no stalls.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_RUN   | issuing butterflies k = 0 .. N/2-1, one per cycle
// ST_DRAIN | no more issues; waiting for the last writes to retire
// ST_DONE  | single-cycle done pulse, then back to idle
module butterfly_stage #(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               active,
    output logic               done,
    output logic               error,
    output logic [LOG_N-1:0]   rd_addr0,
    output logic [LOG_N-1:0]   rd_addr1,
    input  logic [WIDTH-1:0]   rd_data0,
    input  logic [WIDTH-1:0]   rd_data1,
    output logic [LOG_N-2:0]   tf_addr,
    input  logic [WIDTH-1:0]   tf_data,
    output logic [LOG_N-1:0]   wr_addr0,
    output logic [LOG_N-1:0]   wr_addr1,
    output logic [WIDTH-1:0]   wr_data0,
    output logic [WIDTH-1:0]   wr_data1,
    output logic               wr_nd
);

    localparam int H     = WIDTH / 2;
    localparam int S     = 1 << STAGE;
    localparam int TF_SH = LOG_N - 1 - STAGE;

    localparam logic [LOG_N-2:0] K_LAST = (LOG_N-1)'(N / 2 - 1);
    localparam logic [LOG_N-2:0] J_MASK = (LOG_N-1)'(S - 1);
    localparam logic [LOG_N-1:0] S_BIT  = LOG_N'(S);
    localparam logic [LOG_N-2:0] K_ONE  = (LOG_N-1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LOG_N-2:0]   k_q, k_d;
    logic               error_q, error_d;

    // stage 1: operands captured at the end of the issue cycle
    logic               v1_q, v1_d;
    logic [WIDTH-1:0]   a1_q, a1_d;
    logic [WIDTH-1:0]   b1_q, b1_d;
    logic [LOG_N-1:0]   ad0_1_q, ad0_1_d;
    logic [LOG_N-1:0]   ad1_1_q, ad1_1_d;

    // stage 2: twiddle product registered, A carried alongside
    logic               v2_q, v2_d;
    logic [WIDTH-1:0]   a2_q, a2_d;
    logic [WIDTH-1:0]   p2_q, p2_d;
    logic [LOG_N-1:0]   ad0_2_q, ad0_2_d;
    logic [LOG_N-1:0]   ad1_2_q, ad1_2_d;

    // stage 3: write port registers; these hold when no write is pending
    logic               wr_nd_q, wr_nd_d;
    logic [WIDTH-1:0]   wr_data0_q, wr_data0_d;
    logic [WIDTH-1:0]   wr_data1_q, wr_data1_d;
    logic [LOG_N-1:0]   wr_addr0_q, wr_addr0_d;
    logic [LOG_N-1:0]   wr_addr1_q, wr_addr1_d;

    logic [LOG_N-2:0]   j_idx;
    logic [LOG_N-1:0]   addr0_c, addr1_c;
    logic [LOG_N-2:0]   tf_c;
    logic               issue;

    logic signed [H-1:0]     w_re, w_im, b_re, b_im;
    logic signed [2*H-1:0]   m_rr, m_ii, m_ri, m_ir;
    logic [2*H:0]            pr_full, pi_full;
    logic signed [H-1:0]     a_re, a_im, p_re, p_im;
    logic [H:0]              sum_re, sum_im, dif_re, dif_im;
    logic                    unused_bits;

    // Butterfly addressing: k splits into group g = k/s and offset j = k mod s.
    // Element A sits at 2*s*g + j, B is s above it (bit STAGE of A is always 0).
    always_comb begin
        issue   = (state_q == ST_RUN);
        j_idx   = k_q & J_MASK;
        addr0_c = (({1'b0, k_q} >> STAGE) << (STAGE + 1)) | {1'b0, j_idx};
        addr1_c = addr0_c | S_BIT;
        tf_c    = j_idx << TF_SH;
    end

    // Read and twiddle addresses are only driven while issuing, zero otherwise.
    always_comb begin
        rd_addr0 = issue ? addr0_c : '0;
        rd_addr1 = issue ? addr1_c : '0;
        tf_addr  = issue ? tf_c : '0;
    end

    // Sequencer next state: issue counter, drain wait and sticky start error.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + K_ONE;
                end
            end
            ST_DRAIN: begin
                // the write stage holds the last butterfly once stages 1 and 2 are empty
                if (!v1_q && !v2_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start && (state_q != ST_IDLE)) begin
            error_d = 1'b1;
        end
    end

    // Complex multiply P = W*B; the twiddle arrives one cycle after its address,
    // which lines it up with the captured B. Truncate back to Q1.(H-1).
    always_comb begin
        w_re    = tf_data[WIDTH-1:H];
        w_im    = tf_data[H-1:0];
        b_re    = b1_q[WIDTH-1:H];
        b_im    = b1_q[H-1:0];
        m_rr    = (2*H)'(w_re) * (2*H)'(b_re);
        m_ii    = (2*H)'(w_im) * (2*H)'(b_im);
        m_ri    = (2*H)'(w_re) * (2*H)'(b_im);
        m_ir    = (2*H)'(w_im) * (2*H)'(b_re);
        pr_full = (2*H+1)'(m_rr) - (2*H+1)'(m_ii);
        pi_full = (2*H+1)'(m_ri) + (2*H+1)'(m_ir);
    end

    // Sum/difference with one guard bit, halved by an arithmetic shift so the
    // result always fits back into H bits.
    always_comb begin
        a_re   = a2_q[WIDTH-1:H];
        a_im   = a2_q[H-1:0];
        p_re   = p2_q[WIDTH-1:H];
        p_im   = p2_q[H-1:0];
        sum_re = (H+1)'(a_re) + (H+1)'(p_re);
        sum_im = (H+1)'(a_im) + (H+1)'(p_im);
        dif_re = (H+1)'(a_re) - (H+1)'(p_re);
        dif_im = (H+1)'(a_im) - (H+1)'(p_im);
        unused_bits = ^{pr_full[2*H:2*H-1], pr_full[H-2:0],
                        pi_full[2*H:2*H-1], pi_full[H-2:0],
                        sum_re[0], sum_im[0], dif_re[0], dif_im[0]};
    end

    // Pipeline next state: each stage loads only when its predecessor is valid.
    always_comb begin
        v1_d    = issue;
        a1_d    = a1_q;
        b1_d    = b1_q;
        ad0_1_d = ad0_1_q;
        ad1_1_d = ad1_1_q;
        if (issue) begin
            a1_d    = rd_data0;
            b1_d    = rd_data1;
            ad0_1_d = addr0_c;
            ad1_1_d = addr1_c;
        end

        v2_d    = v1_q;
        a2_d    = a2_q;
        p2_d    = p2_q;
        ad0_2_d = ad0_2_q;
        ad1_2_d = ad1_2_q;
        if (v1_q) begin
            a2_d    = a1_q;
            p2_d    = {pr_full[2*H-2:H-1], pi_full[2*H-2:H-1]};
            ad0_2_d = ad0_1_q;
            ad1_2_d = ad1_1_q;
        end

        wr_nd_d    = v2_q;
        wr_data0_d = wr_data0_q;
        wr_data1_d = wr_data1_q;
        wr_addr0_d = wr_addr0_q;
        wr_addr1_d = wr_addr1_q;
        if (v2_q) begin
            wr_data0_d = {sum_re[H:1], sum_im[H:1]};
            wr_data1_d = {dif_re[H:1], dif_im[H:1]};
            wr_addr0_d = ad0_2_q;
            wr_addr1_d = ad1_2_q;
        end
    end

    // All state; reset aborts any frame in flight and clears the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            error_q    <= 1'b0;
            v1_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            ad0_1_q    <= '0;
            ad1_1_q    <= '0;
            v2_q       <= 1'b0;
            a2_q       <= '0;
            p2_q       <= '0;
            ad0_2_q    <= '0;
            ad1_2_q    <= '0;
            wr_nd_q    <= 1'b0;
            wr_data0_q <= '0;
            wr_data1_q <= '0;
            wr_addr0_q <= '0;
            wr_addr1_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            error_q    <= error_d;
            v1_q       <= v1_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            ad0_1_q    <= ad0_1_d;
            ad1_1_q    <= ad1_1_d;
            v2_q       <= v2_d;
            a2_q       <= a2_d;
            p2_q       <= p2_d;
            ad0_2_q    <= ad0_2_d;
            ad1_2_q    <= ad1_2_d;
            wr_nd_q    <= wr_nd_d;
            wr_data0_q <= wr_data0_d;
            wr_data1_q <= wr_data1_d;
            wr_addr0_q <= wr_addr0_d;
            wr_addr1_q <= wr_addr1_d;
        end
    end

    // Status outputs decode from state; the done cycle itself is not active.
    always_comb begin
        active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done     = (state_q == ST_DONE);
        error    = error_q;
        wr_nd    = wr_nd_q;
        wr_data0 = wr_data0_q;
        wr_data1 = wr_data1_q;
        wr_addr0 = wr_addr0_q;
        wr_addr1 = wr_addr1_q;
    end

endmodule

// File: tb/tb_butterfly_stage.sv
// Bench for butterfly_stage: one instance per stage of an 8-point FFT, all
// started together, checked cycle by cycle against an arithmetic model.
module tb_butterfly_stage;

    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int WIDTH = 32;
    localparam int H     = 16;
    localparam int NI    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [N];
    logic [WIDTH-1:0] rom [N/2];

    logic             act_v [NI];
    logic             done_v [NI];
    logic             err_v [NI];
    logic             nd_v [NI];
    logic [LOG_N-1:0] ra0_v [NI];
    logic [LOG_N-1:0] ra1_v [NI];
    logic [LOG_N-1:0] wa0_v [NI];
    logic [LOG_N-1:0] wa1_v [NI];
    logic [LOG_N-2:0] tfa_v [NI];
    logic [WIDTH-1:0] rd0_v [NI];
    logic [WIDTH-1:0] rd1_v [NI];
    logic [WIDTH-1:0] tfd_v [NI];
    logic [WIDTH-1:0] wd0_v [NI];
    logic [WIDTH-1:0] wd1_v [NI];

    logic [WIDTH-1:0] cap0 [NI][N/2];
    logic [WIDTH-1:0] cap1 [NI][N/2];

    int tests = 0;
    int fails = 0;
    bit err_exp = 1'b0;

    // combinational-read upstream RAM
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rd0_v[i] = mem[ra0_v[i]];
            rd1_v[i] = mem[ra1_v[i]];
        end
    end

    // registered twiddle ROM
    always_ff @(posedge clk) begin
        for (int i = 0; i < NI; i++) tfd_v[i] <= rom[tfa_v[i]];
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        butterfly_stage #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH), .STAGE(g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .active   (act_v[g]),
            .done     (done_v[g]),
            .error    (err_v[g]),
            .rd_addr0 (ra0_v[g]),
            .rd_addr1 (ra1_v[g]),
            .rd_data0 (rd0_v[g]),
            .rd_data1 (rd1_v[g]),
            .tf_addr  (tfa_v[g]),
            .tf_data  (tfd_v[g]),
            .wr_addr0 (wa0_v[g]),
            .wr_addr1 (wa1_v[g]),
            .wr_data0 (wd0_v[g]),
            .wr_data1 (wd1_v[g]),
            .wr_nd    (nd_v[g])
        );
    end

    function automatic int m_a0(input int st, input int k);
        int s;
        s = 1 << st;
        return 2 * s * (k / s) + (k % s);
    endfunction

    function automatic int m_tf(input int st, input int k);
        int s;
        s = 1 << st;
        return (k % s) * (N / (2 * s));
    endfunction

    // X0 (second=0) or X1 (second=1) for butterfly k of stage st, plain arithmetic
    function automatic logic [WIDTH-1:0] m_x(input int st, input int k, input bit second);
        int a0, a1;
        logic [WIDTH-1:0] av, bv, wv;
        longint ar, ai, br, bi, wr, wi, pr, pi, xr, xi;
        logic [H-1:0] pr16, pi16, xr16, xi16;
        a0 = m_a0(st, k);
        a1 = a0 + (1 << st);
        av = mem[a0];
        bv = mem[a1];
        wv = rom[m_tf(st, k)];
        ar = longint'($signed(av[31:16]));
        ai = longint'($signed(av[15:0]));
        br = longint'($signed(bv[31:16]));
        bi = longint'($signed(bv[15:0]));
        wr = longint'($signed(wv[31:16]));
        wi = longint'($signed(wv[15:0]));
        pr = wr * br - wi * bi;
        pi = wr * bi + wi * br;
        pr16 = H'(pr >>> 15);
        pi16 = H'(pi >>> 15);
        pr = longint'($signed(pr16));
        pi = longint'($signed(pi16));
        xr = second ? (ar - pr) : (ar + pr);
        xi = second ? (ai - pi) : (ai + pi);
        xr16 = H'(xr >>> 1);
        xi16 = H'(xi >>> 1);
        return {xr16, xi16};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N; i++) mem[i] = $urandom();
        for (int i = 0; i < N/2; i++) rom[i] = $urandom();
    endtask

    // One frame: start in cycle 0, optional extra start pulse in cycle inj,
    // every output class checked in cycles 1..N/2+6.
    task automatic run_frame(input int inj);
        bit errx;
        logic [3:0] ctl_exp;
        logic [2*LOG_N+LOG_N-2:0] ra_exp;
        logic [2*LOG_N+2*WIDTH-1:0] wr_exp;
        int k;
        errx = err_exp;
        @(posedge clk); #1 start = 1'b1;
        for (int cyc = 1; cyc <= N/2 + 6; cyc++) begin
            @(posedge clk); #1 start = (inj == cyc);
            if (inj > 0 && cyc == inj + 1) errx = 1'b1;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                ctl_exp = {(cyc <= N/2 + 3), (cyc == N/2 + 4),
                           (cyc >= 4 && cyc <= N/2 + 3), errx};
                tests++;
                if ({act_v[i], done_v[i], nd_v[i], err_v[i]} !== ctl_exp) begin
                    fails++;
                    $display("FAIL ctrl stage%0d cyc%0d act/done/nd/err got %b exp %b",
                             i, cyc, {act_v[i], done_v[i], nd_v[i], err_v[i]}, ctl_exp);
                end
                if (cyc <= N/2) begin
                    k = cyc - 1;
                    ra_exp = {LOG_N'(m_a0(i, k)), LOG_N'(m_a0(i, k) + (1 << i)),
                              (LOG_N-1)'(m_tf(i, k))};
                    tests++;
                    if ({ra0_v[i], ra1_v[i], tfa_v[i]} !== ra_exp) begin
                        fails++;
                        $display("FAIL rdaddr stage%0d k%0d got %h exp %h",
                                 i, k, {ra0_v[i], ra1_v[i], tfa_v[i]}, ra_exp);
                    end
                end
                if (cyc >= 4) begin
                    k = (cyc <= N/2 + 3) ? cyc - 4 : N/2 - 1;
                    wr_exp = {LOG_N'(m_a0(i, k)), LOG_N'(m_a0(i, k) + (1 << i)),
                              m_x(i, k, 1'b0), m_x(i, k, 1'b1)};
                    if (cyc <= N/2 + 3) begin
                        cap0[i][k] = wd0_v[i];
                        cap1[i][k] = wd1_v[i];
                    end
                    tests++;
                    if ({wa0_v[i], wa1_v[i], wd0_v[i], wd1_v[i]} !== wr_exp) begin
                        fails++;
                        $display("FAIL wr stage%0d cyc%0d k%0d got %h exp %h",
                                 i, cyc, k, {wa0_v[i], wa1_v[i], wd0_v[i], wd1_v[i]}, wr_exp);
                    end
                end
            end
        end
        @(posedge clk); #1 start = 1'b0;
        err_exp = errx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({act_v[i], done_v[i], err_v[i], nd_v[i], ra0_v[i], ra1_v[i], tfa_v[i],
                 wa0_v[i], wa1_v[i], wd0_v[i], wd1_v[i]} !== '0) begin
                fails++;
                $display("FAIL reset stage%0d outputs not all zero (act %b done %b err %b nd %b wd0 %h)",
                         i, act_v[i], done_v[i], err_v[i], nd_v[i], wd0_v[i]);
            end
        end
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        fill_random();
        mem[0] = 32'h4000_0000;
        mem[2] = 32'h2000_0000;
        rom[0] = 32'h7FFF_0000;
        mem[1] = 32'h0000_0000;
        mem[3] = 32'h0000_4000;
        rom[2] = 32'h0000_8000;
        run_frame(0);
        tests++;
        if ({cap0[1][0], cap1[1][0]} !== {32'h2FFF_0000, 32'h1000_0000}) begin
            fails++;
            $display("FAIL vec_real got %h %h exp 2fff0000 10000000", cap0[1][0], cap1[1][0]);
        end
        tests++;
        if ({cap0[1][1], cap1[1][1]} !== {32'h2000_0000, 32'hE000_0000}) begin
            fails++;
            $display("FAIL vec_minus_i got %h %h exp 20000000 e0000000", cap0[1][1], cap1[1][1]);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(0);
        end
    endtask

    task automatic test_extremes();
        logic [H-1:0] pick [5];
        pick[0] = 16'h8000; pick[1] = 16'h7FFF; pick[2] = 16'h0000;
        pick[3] = 16'h0001; pick[4] = 16'hFFFF;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++)
                mem[i] = {pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)]};
            for (int i = 0; i < N/2; i++)
                rom[i] = {pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)]};
            run_frame(0);
        end
    endtask

    task automatic test_start_while_active();
        fill_random();
        run_frame(3);
    endtask

    task automatic test_midframe_reset();
        fill_random();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        err_exp = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tests++;
            if ({act_v[i], done_v[i], err_v[i], nd_v[i], ra0_v[i], ra1_v[i], tfa_v[i],
                 wa0_v[i], wa1_v[i], wd0_v[i], wd1_v[i]} !== '0) begin
                fails++;
                $display("FAIL midreset stage%0d outputs not zero (act %b err %b nd %b wd0 %h)",
                         i, act_v[i], err_v[i], nd_v[i], wd0_v[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                tests++;
                if ({act_v[i], done_v[i], nd_v[i]} !== 3'b000) begin
                    fails++;
                    $display("FAIL post_reset stage%0d cyc%0d act/done/nd got %b exp 000",
                             i, c, {act_v[i], done_v[i], nd_v[i]});
                end
            end
        end
        run_frame(0);
    endtask

    task automatic test_start_on_done();
        fill_random();
        run_frame(N/2 + 4);
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_frame(0);
        fill_random();
        run_frame(0);
    endtask

    initial begin
        fill_random();
        test_reset();
        test_vectors();
        test_random();
        test_extremes();
        test_start_while_active();
        test_midframe_reset();
        test_start_on_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
